// File: rtl/bus_pkg.sv
// Shared bus types: arbiter state, master identifier and the request bundle
// that the caches, the arbiter and the memory controller all talk in.
package bus_pkg;

  localparam int unsigned BusAddressWidth = 32;
  localparam int unsigned BusDataWidth    = 32;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} ArbState_t;

  typedef logic MasterId_t;
  localparam MasterId_t MASTER0 = 1'b0;
  localparam MasterId_t MASTER1 = 1'b1;

  typedef struct packed {
    logic                       cycle;
    logic                       strobe;
    logic                       read_write;
    logic [BusAddressWidth-1:0] address;
    logic [BusDataWidth-1:0]    data_out;
  } BusRequest_t;

  // On a tie the master that did not own the bus last time wins.
  function automatic MasterId_t rr_winner(input MasterId_t last_grant);
    return ~last_grant;
  endfunction

endpackage

// File: rtl/outstanding_counter.sv
// Up/down counter of accepted-but-unacknowledged strobes. Saturates at both
// ends; an acknowledge with nothing outstanding latches a sticky error.
module outstanding_counter #(
  parameter int unsigned MaxCount   = 8,
  parameter int unsigned CountWidth = $clog2(MaxCount + 1)
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_increment,
  input  logic i_decrement,
  output logic o_full,
  output logic o_empty
);

  localparam logic [CountWidth-1:0] MaxValue = CountWidth'(MaxCount);
  localparam logic [CountWidth-1:0] One      = CountWidth'(1);

  logic [CountWidth-1:0] r_count;
  logic                  r_underflow;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (i_increment && !i_decrement) begin
      if (r_count != MaxValue) r_count <= r_count + One;
    end else if (i_decrement && !i_increment) begin
      if (r_count != '0) r_count <= r_count - One;
      else               r_underflow <= 1'b1;
    end
  end

  assign o_full  = (r_count == MaxValue);
  assign o_empty = (r_count == '0);

  // Only meaningful in simulation; synthesis drops the property.
  assert property (@(posedge i_clock) disable iff (!i_reset_n) !r_underflow);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared pipelined bus between the I-cache refill
// engine (M0) and the load/store unit (M1); ownership spans a whole bus cycle.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_m0_cycle,
  input  logic                    i_m1_cycle,
  input  logic                    i_m0_strobe,
  input  logic                    i_m1_strobe,
  input  logic                    i_m0_read_write,
  input  logic                    i_m1_read_write,
  input  logic [AddressWidth-1:0] i_m0_address,
  input  logic [AddressWidth-1:0] i_m1_address,
  input  logic [DataWidth-1:0]    i_m0_data_out,
  input  logic [DataWidth-1:0]    i_m1_data_out,
  output logic                    o_m0_acknowledge,
  output logic                    o_m1_acknowledge,
  output logic                    o_m0_stall,
  output logic                    o_m1_stall,
  output logic [DataWidth-1:0]    o_m0_data_in,
  output logic [DataWidth-1:0]    o_m1_data_in,
  output logic                    o_bus_cycle,
  output logic                    o_bus_strobe,
  output logic                    o_bus_read_write,
  output logic [AddressWidth-1:0] o_memory_address,
  output logic [DataWidth-1:0]    o_memory_data_out,
  input  logic [DataWidth-1:0]    i_memory_data_in,
  input  logic                    i_bus_acknowledge,
  input  logic                    i_bus_stall,
  output logic [1:0]              o_grant
);

  ArbState_t r_state, w_state_next;
  MasterId_t r_owner, w_owner_next;
  MasterId_t r_last_grant, w_last_grant_next;

  logic [1:0]              w_m_cycle, w_m_strobe, w_m_read_write;
  logic [1:0]              w_m_acknowledge, w_m_stall, w_grant;
  logic [AddressWidth-1:0] w_m_address [2];
  logic [DataWidth-1:0]    w_m_data_out [2];
  logic                    w_full, w_empty;

  assign w_m_cycle       = {i_m1_cycle, i_m0_cycle};
  assign w_m_strobe      = {i_m1_strobe, i_m0_strobe};
  assign w_m_read_write  = {i_m1_read_write, i_m0_read_write};
  assign w_m_address[0]  = i_m0_address;
  assign w_m_address[1]  = i_m1_address;
  assign w_m_data_out[0] = i_m0_data_out;
  assign w_m_data_out[1] = i_m1_data_out;

  outstanding_counter #(.MaxCount(MaxOutstanding)) u_outstanding (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_increment (o_bus_strobe && !i_bus_stall),
    .i_decrement (i_bus_acknowledge),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_owner      <= MASTER0;
      r_last_grant <= MASTER1;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_grant_next = r_last_grant;
    o_bus_cycle       = 1'b0;
    o_bus_strobe      = 1'b0;
    o_bus_read_write  = 1'b0;
    o_memory_address  = '0;
    o_memory_data_out = '0;
    w_m_stall         = 2'b11;
    w_m_acknowledge   = 2'b00;
    w_grant           = 2'b00;
    case (r_state)
      IDLE: begin
        if (|w_m_cycle) begin
          if (&w_m_cycle) w_owner_next = rr_winner(r_last_grant);
          else            w_owner_next = w_m_cycle[1] ? MASTER1 : MASTER0;
          w_state_next = (w_owner_next == MASTER1) ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        w_grant[r_owner]  = 1'b1;
        // Cycle stays up on the owner's release until every strobe is acked.
        o_bus_cycle       = w_m_cycle[r_owner] || !w_empty;
        o_bus_strobe      = w_m_cycle[r_owner] && w_m_strobe[r_owner] && !w_full;
        o_bus_read_write  = w_m_read_write[r_owner];
        o_memory_address  = w_m_address[r_owner];
        o_memory_data_out = w_m_data_out[r_owner];
        w_m_stall[r_owner]       = i_bus_stall || w_full;
        w_m_acknowledge[r_owner] = i_bus_acknowledge && w_m_cycle[r_owner];
        if (!w_m_cycle[r_owner]) begin
          if (w_empty) begin
            w_state_next      = IDLE;
            w_last_grant_next = r_owner;
          end else begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        w_grant[r_owner] = 1'b1;
        o_bus_cycle      = 1'b1;
        if (w_empty) begin
          w_state_next      = IDLE;
          w_last_grant_next = r_owner;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_m0_acknowledge = w_m_acknowledge[0];
  assign o_m1_acknowledge = w_m_acknowledge[1];
  assign o_m0_stall       = w_m_stall[0];
  assign o_m1_stall       = w_m_stall[1];
  assign o_m0_data_in     = i_memory_data_in;
  assign o_m1_data_in     = i_memory_data_in;
  assign o_grant          = w_grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: master drivers push expected read data into per-master
// queues; a monitor pops them on every routed acknowledge.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic        o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall;
  logic [31:0] o_m0_dat, o_m1_dat;
  logic        o_bus_cyc, o_bus_stb, o_bus_we;
  logic [31:0] o_mem_adr, o_mem_dat;
  logic [31:0] mem_din = 32'hDEAD_BEEF;
  logic        bus_ack = 1'b0;
  logic        bus_stall = 1'b0;
  logic [1:0]  o_grant;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [31:0] adr; int due;} slv_t;
  slv_t        slv_q[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] acc_log[$];
  int          tick = 0;
  int          accepted = 0;
  int          acked = 0;
  int          peak = 0;
  int          ack_cnt [2];
  bit          slave_hold = 1'b0;
  bit          stall_mode = 1'b0;
  logic [1:0]  prev_grant = 2'b00;

  bus_arbiter dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_m0_cycle(m_cyc[0]), .i_m1_cycle(m_cyc[1]),
    .i_m0_strobe(m_stb[0]), .i_m1_strobe(m_stb[1]),
    .i_m0_read_write(m_we[0]), .i_m1_read_write(m_we[1]),
    .i_m0_address(m_adr[0]), .i_m1_address(m_adr[1]),
    .i_m0_data_out(m_dat[0]), .i_m1_data_out(m_dat[1]),
    .o_m0_acknowledge(o_m0_ack), .o_m1_acknowledge(o_m1_ack),
    .o_m0_stall(o_m0_stall), .o_m1_stall(o_m1_stall),
    .o_m0_data_in(o_m0_dat), .o_m1_data_in(o_m1_dat),
    .o_bus_cycle(o_bus_cyc), .o_bus_strobe(o_bus_stb), .o_bus_read_write(o_bus_we),
    .o_memory_address(o_mem_adr), .o_memory_data_out(o_mem_dat),
    .i_memory_data_in(mem_din), .i_bus_acknowledge(bus_ack), .i_bus_stall(bus_stall),
    .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic stall_of(input int m);
    return (m == 0) ? o_m0_stall : o_m1_stall;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no response expected one", name);
  endtask

  task automatic sb_pop(input int m, input logic [31:0] dat);
    logic [31:0] e;
    checks++;
    if ((m == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
      errors++;
      $display("FAIL ack_m%0d: got acknowledge data %h expected no acknowledge", m, dat);
    end else begin
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      ack_cnt[m]++;
      $display("ack m%0d data %h", m, dat);
      if (dat !== e) begin
        errors++;
        $display("FAIL rdata_m%0d: got %h expected %h", m, dat, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Pipelined master: one strobe per accepted beat; early_drop releases Cycle
  // right after the last strobe and expects every acknowledge to be swallowed.
  task automatic burst(input int m, input logic [31:0] base, input int n, input bit early_drop);
    int guard;
    m_cyc[m] = 1'b1;
    for (int b = 0; b < n; b++) begin
      m_stb[m] = 1'b1;
      m_adr[m] = base + 32'(4 * b);
      m_we[m]  = m_adr[m][2];
      m_dat[m] = ~m_adr[m];
      guard = 0;
      do begin @(negedge clk); guard++; end while (rst_n && stall_of(m) && guard < 200);
      if (!rst_n) begin m_cyc[m] = 1'b0; m_stb[m] = 1'b0; return; end
      if (guard >= 200) begin timeout("accept"); break; end
      if (!early_drop) begin
        if (m == 0) exp_q0.push_back(rdata(m_adr[m]));
        else        exp_q1.push_back(rdata(m_adr[m]));
      end
      step();
    end
    m_stb[m] = 1'b0;
    if (!early_drop) begin
      guard = 0;
      while (rst_n && ((m == 0) ? exp_q0.size() : exp_q1.size()) != 0 && guard < 200) begin
        step(); guard++;
      end
      if (guard >= 200) timeout("acks");
    end
    m_cyc[m] = 1'b0;
  endtask

  // Slave: accepts whenever not stalled, acknowledges two cycles later.
  always begin
    @(posedge clk); #2;
    tick++;
    if (!rst_n) slv_q.delete();
    if (rst_n && !slave_hold && slv_q.size() > 0 && slv_q[0].due <= tick) begin
      bus_ack = 1'b1;
      mem_din = rdata(slv_q[0].adr);
      void'(slv_q.pop_front());
      acked++;
    end else begin
      bus_ack = 1'b0;
      mem_din = 32'hDEAD_BEEF;
    end
    bus_stall = stall_mode && (tick % 3 == 0);
  end

  always @(negedge clk) begin
    if (rst_n && o_bus_cyc && o_bus_stb && !bus_stall) begin
      slv_q.push_back('{o_mem_adr, tick + 2});
      acc_log.push_back(o_mem_adr);
      accepted++;
      if (accepted - acked > peak) peak = accepted - acked;
      check("wdata", o_mem_dat, ~o_mem_adr);
      check("we", {31'd0, o_bus_we}, {31'd0, o_mem_adr[2]});
    end
  end

  // Monitor: routed acknowledges, non-owner blocking, idle turnaround.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_m0_ack) sb_pop(0, o_m0_dat);
      if (o_m1_ack) sb_pop(1, o_m1_dat);
      if (o_grant != 2'b01) check("m0_blocked", {30'd0, o_m0_stall, o_m0_ack}, 32'h2);
      if (o_grant != 2'b10) check("m1_blocked", {30'd0, o_m1_stall, o_m1_ack}, 32'h2);
      if (o_grant == 2'b00) check("idle_cyc", {31'd0, o_bus_cyc}, 32'h0);
      if (o_grant != prev_grant)
        check("turnaround", {31'd0, (prev_grant != 2'b00) && (o_grant != 2'b00)}, 32'h0);
      prev_grant = o_grant;
    end else begin
      prev_grant = 2'b00;
    end
  end

  initial begin
    int base_acks;
    int acc0;
    int guard;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_adr[i] = '0; m_dat[i] = '0; ack_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_bus_cyc", {31'd0, o_bus_cyc}, 32'h0);
    check("rst_bus_stb", {31'd0, o_bus_stb}, 32'h0);
    check("rst_bus_we", {31'd0, o_bus_we}, 32'h0);
    check("rst_mem_adr", o_mem_adr, 32'h0);
    check("rst_mem_dat", o_mem_dat, 32'h0);
    check("rst_stalls", {30'd0, o_m0_stall, o_m1_stall}, 32'h3);
    check("rst_acks", {30'd0, o_m0_ack, o_m1_ack}, 32'h0);
    check("rst_grant", {30'd0, o_grant}, 32'h0);
    step(); rst_n = 1'b1;
    step();

    // 8-beat M0 line fill, BusCycle one cycle after Cycle.
    base_acks = ack_cnt[0];
    fork
      burst(0, 32'h100, 8, 1'b0);
      begin
        @(negedge clk);
        check("lat_cyc_n", {31'd0, o_bus_cyc}, 32'h0);
        check("lat_stall_n", {31'd0, o_m0_stall}, 32'h1);
        @(negedge clk);
        check("lat_cyc_n1", {31'd0, o_bus_cyc}, 32'h1);
        check("lat_grant", {30'd0, o_grant}, 32'h1);
        check("lat_adr", o_mem_adr, 32'h100);
      end
    join
    check("m0_ack_count", ack_cnt[0] - base_acks, 8);
    repeat (2) @(negedge clk);
    check("t1_idle_grant", {30'd0, o_grant}, 32'h0);
    step();

    // Tie after M0 owned last: M1 wins.
    acc_log.delete();
    fork
      burst(0, 32'h180, 4, 1'b0);
      burst(1, 32'h200, 4, 1'b0);
    join
    check("tie_rr_first", acc_log[0], 32'h200);
    check("tie_rr_second", acc_log[4], 32'h180);
    repeat (2) step();

    // M0 requests in the middle of an M1 burst; slave stalls now and then.
    acc_log.delete();
    stall_mode = 1'b1;
    fork
      burst(1, 32'h400, 8, 1'b0);
      begin repeat (3) step(); burst(0, 32'h500, 4, 1'b0); end
    join
    stall_mode = 1'b0;
    for (int i = 0; i < 8; i++) check("no_interleave", acc_log[i], 32'h400 + 32'(4 * i));
    check("m0_after_m1", acc_log[8], 32'h500);
    repeat (2) step();

    // Nine strobes with acknowledges withheld: the ninth must wait.
    slave_hold = 1'b1;
    acc0 = accepted;
    peak = accepted - acked;
    fork
      burst(0, 32'h600, 9, 1'b0);
      begin
        guard = 0;
        while (accepted - acc0 < 8 && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) timeout("fill_8");
        repeat (4) begin
          @(negedge clk);
          check("full_stall", {31'd0, o_m0_stall}, 32'h1);
          check("full_stb", {31'd0, o_bus_stb}, 32'h0);
        end
        check("full_accepted", accepted - acc0, 8);
        slave_hold = 1'b0;
      end
    join
    check("peak_outstanding", peak, 8);
    repeat (2) step();

    // M1 drops Cycle with 3 outstanding; M0 waits for the drain.
    acc_log.delete();
    base_acks = ack_cnt[1];
    slave_hold = 1'b1;
    burst(1, 32'h700, 3, 1'b1);
    fork
      burst(0, 32'h780, 2, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          check("drain_cyc", {31'd0, o_bus_cyc}, 32'h1);
          check("drain_stb", {31'd0, o_bus_stb}, 32'h0);
          check("drain_grant", {30'd0, o_grant}, 32'h2);
        end
        slave_hold = 1'b0;
      end
    join
    check("drain_swallowed", ack_cnt[1] - base_acks, 0);
    check("drain_then_m0", acc_log[3], 32'h780);
    repeat (2) step();

    // Reset at beat 4 of an M0 burst.
    acc0 = accepted;
    fork
      burst(0, 32'h800, 8, 1'b0);
      begin
        guard = 0;
        while (accepted - acc0 < 4 && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) timeout("beat_4");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_cyc", {31'd0, o_bus_cyc}, 32'h0);
        check("arst_stb", {31'd0, o_bus_stb}, 32'h0);
        check("arst_acks", {30'd0, o_m0_ack, o_m1_ack}, 32'h0);
        check("arst_grant", {30'd0, o_grant}, 32'h0);
        repeat (2) step();
        exp_q0.delete();
        exp_q1.delete();
        rst_n = 1'b1;
      end
    join
    @(negedge clk);
    check("rel_grant", {30'd0, o_grant}, 32'h0);
    check("rel_outstanding", 32'(dut.u_outstanding.r_count), 32'h0);
    step();
    acc_log.delete();
    fork
      burst(0, 32'h900, 2, 1'b0);
      burst(1, 32'h940, 2, 1'b0);
    join
    check("post_rst_first", acc_log[0], 32'h900);
    check("post_rst_second", acc_log[2], 32'h940);
    repeat (3) step();
    check("leftover_m0", exp_q0.size(), 0);
    check("leftover_m1", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
